// File: rtl/rotation_match_pkg.sv
// Shared types, constants and the rotate-left helper for the rotation match finder.
// Optional feature macro: ROTATION_MATCH_MATCH_ALL_EN (used by rotation_match_finder).
package rotation_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SSW   = $clog2(DEFAULT_WIDTH);

  // Rotate-left: bits leaving the MSB re-enter at the LSB.
  // Doubling the word turns the rotate into a plain shift of the upper half.
  function automatic logic [DEFAULT_WIDTH-1:0] rotl(
    input logic [DEFAULT_WIDTH-1:0] value,
    input logic [DEFAULT_SSW-1:0]   amount
  );
    logic [2*DEFAULT_WIDTH-1:0] dbl;
    dbl = {value, value} << amount;
    return dbl[2*DEFAULT_WIDTH-1:DEFAULT_WIDTH];
  endfunction

endpackage

// File: rtl/rotl_word.sv
// Combinational rotate-left of a WIDTH-bit word by an SSW-bit amount.
// At the default width the shared package helper is used so RTL and bench
// share one definition of the rotation.
module rotl_word
  import rotation_match_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SSW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SSW-1:0]   amount,
  output logic [WIDTH-1:0] result
);

  generate
    if (WIDTH == DEFAULT_WIDTH) begin : g_pkg
      assign result = rotl(value, amount);
    end else begin : g_generic
      logic [2*WIDTH-1:0] dbl;
      assign dbl    = {value, value} << amount;
      assign result = dbl[2*WIDTH-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/rotation_match_finder.sv
// Rotation match finder: captures a data word and a target, steps the rotate
// amount 0..WIDTH-1 one per clock and reports the first rotation that matches.
// Optional feature macro: ROTATION_MATCH_MATCH_ALL_EN -- scan all amounts and
// report every matching amount in match_mask (lowest one in amount).
module rotation_match_finder
  import rotation_match_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SSW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] target_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [SSW-1:0]   amount,
  output logic [WIDTH-1:0] match_mask
);

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] data_r, data_nxt;
  logic [WIDTH-1:0] target_r, target_nxt;
  logic [SSW-1:0]   cnt_r, cnt_nxt;
  logic             found_r, found_nxt;
  logic [SSW-1:0]   amount_r, amount_nxt;
  logic             done_r, done_nxt;
  logic             busy_r, busy_nxt;
  logic [WIDTH-1:0] rot_word_s;
  logic             hit_s;
  logic             last_s;

  rotl_word #(
    .WIDTH (WIDTH),
    .SSW   (SSW)
  ) u_rotl (
    .value  (data_r),
    .amount (cnt_r),
    .result (rot_word_s)
  );

  assign hit_s  = (rot_word_s == target_r);
  assign last_s = (cnt_r == SSW'(WIDTH - 1));

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode: early exit on the first hit unless every amount is scanned.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
`ifdef ROTATION_MATCH_MATCH_ALL_EN
        if (last_s) begin
`else
        if (hit_s || last_s) begin
`endif
          state_nxt = DONE;
        end else begin
          state_nxt = SCAN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ROTATION_MATCH_MATCH_ALL_EN
  logic [WIDTH-1:0] mask_r, mask_nxt;
`endif

  // Output/datapath decode: next values for the capture, counter and result registers.
  always_comb begin
    data_nxt   = data_r;
    target_nxt = target_r;
    cnt_nxt    = cnt_r;
    found_nxt  = found_r;
    amount_nxt = amount_r;
    done_nxt   = 1'b0;
`ifdef ROTATION_MATCH_MATCH_ALL_EN
    mask_nxt   = mask_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          data_nxt   = data_in;
          target_nxt = target_in;
          cnt_nxt    = {SSW{1'b0}};
          found_nxt  = 1'b0;
          amount_nxt = {SSW{1'b0}};
`ifdef ROTATION_MATCH_MATCH_ALL_EN
          mask_nxt   = {WIDTH{1'b0}};
`endif
        end else begin
          data_nxt = data_r;
        end
      end
      SCAN: begin
`ifdef ROTATION_MATCH_MATCH_ALL_EN
        // Every amount is evaluated; the lowest hit is kept in amount.
        if (hit_s) begin
          mask_nxt = mask_r | ({{(WIDTH-1){1'b0}}, 1'b1} << cnt_r);
          if (!found_r) begin
            found_nxt  = 1'b1;
            amount_nxt = cnt_r;
          end else begin
            found_nxt = found_r;
          end
        end else begin
          mask_nxt = mask_r;
        end
        if (last_s) begin
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_r + SSW'(1);
        end
`else
        if (hit_s) begin
          found_nxt  = 1'b1;
          amount_nxt = cnt_r;
          done_nxt   = 1'b1;
        end else if (last_s) begin
          found_nxt  = 1'b0;
          amount_nxt = {SSW{1'b0}};
          done_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_r + SSW'(1);
        end
`endif
      end
      DONE:    done_nxt = 1'b0;
      default: done_nxt = 1'b0;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= {WIDTH{1'b0}};
      target_r <= {WIDTH{1'b0}};
      cnt_r    <= {SSW{1'b0}};
      found_r  <= 1'b0;
      amount_r <= {SSW{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      data_r   <= data_nxt;
      target_r <= target_nxt;
      cnt_r    <= cnt_nxt;
      found_r  <= found_nxt;
      amount_r <= amount_nxt;
      done_r   <= done_nxt;
      busy_r   <= busy_nxt;
    end
  end

`ifdef ROTATION_MATCH_MATCH_ALL_EN
  // Match mask register, cleared on reset and on each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= {WIDTH{1'b0}};
    end else begin
      mask_r <= mask_nxt;
    end
  end
  assign match_mask = mask_r;
`else
  assign match_mask = {WIDTH{1'b0}};
`endif

  assign busy   = busy_r;
  assign done   = done_r;
  assign found  = found_r;
  assign amount = amount_r;

endmodule

// File: tb/tb_rotation_match_finder.sv
// Directed self-checking bench for rotation_match_finder.
// Expectations follow ROTATION_MATCH_MATCH_ALL_EN when it is defined.
module tb_rotation_match_finder;
  import rotation_match_pkg::*;

  localparam int W  = DEFAULT_WIDTH;
  localparam int SW = $clog2(W);
`ifdef ROTATION_MATCH_MATCH_ALL_EN
  localparam bit MALL = 1'b1;
`else
  localparam bit MALL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  data_in;
  logic [W-1:0]  target_in;
  logic          busy;
  logic          done;
  logic          found;
  logic [SW-1:0] amount;
  logic [W-1:0]  match_mask;

  int tests_run = 0;
  int failed    = 0;

  rotation_match_finder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .target_in  (target_in),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .amount     (amount),
    .match_mask (match_mask)
  );

  always #5 clk = ~clk;

  // Present a start pulse; returns at the first falling edge after the accepting edge.
  task automatic do_start(input logic [W-1:0] d, input logic [W-1:0] t);
    @(negedge clk);
    data_in   = d;
    target_in = t;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Count falling-edge samples until done (first sample index = n0); lat = -1 on timeout.
  task automatic wait_done(input int n0, output int lat, output int busy_cnt);
    int n;
    n        = n0;
    lat      = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = 16'h0000; target_in = 16'h0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, found, amount, match_mask} !== {1'b0, 1'b0, 1'b0, {SW{1'b0}}, 16'h0000}) begin
      failed++;
      $display("FAIL reset_outputs: busy=%b done=%b found=%b amount=%0d mask=%h, required all zero",
               busy, done, found, amount, match_mask);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
    tests_run++;
    if (rotl(16'h0001, 4'd3) !== 16'h0008 || rotl(16'h8001, 4'd1) !== 16'h0003) begin
      failed++;
      $display("FAIL pkg_rotl: got %h %h, required 0008 0003", rotl(16'h0001, 4'd3), rotl(16'h8001, 4'd1));
    end
  endtask

  task automatic test_basic_match();
    int lat, bc;
    do_start(16'h0001, 16'h0008);
    wait_done(1, lat, bc);
    tests_run++;
    if (lat !== (MALL ? 17 : 5)) begin
      failed++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, MALL ? 17 : 5);
    end
    tests_run++;
    if (found !== 1'b1 || amount !== 4'd3) begin
      failed++;
      $display("FAIL basic_result: found=%b amount=%0d, required 1 3", found, amount);
    end
    tests_run++;
    if (bc !== (MALL ? 17 : 5)) begin
      failed++;
      $display("FAIL basic_busy_cycles: got %0d, required %0d", bc, MALL ? 17 : 5);
    end
    tests_run++;
    if (match_mask !== (MALL ? 16'h0008 : 16'h0000)) begin
      failed++;
      $display("FAIL basic_mask: got %h, required %h", match_mask, MALL ? 16'h0008 : 16'h0000);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || found !== 1'b1 || amount !== 4'd3) begin
      failed++;
      $display("FAIL basic_after_done: done=%b busy=%b found=%b amount=%0d, required 0 0 1 3",
               done, busy, found, amount);
    end
  endtask

  task automatic test_identity();
    int lat, bc;
    do_start(16'hA5C3, 16'hA5C3);
    wait_done(1, lat, bc);
    tests_run++;
    if (lat !== (MALL ? 17 : 2) || found !== 1'b1 || amount !== 4'd0) begin
      failed++;
      $display("FAIL identity: lat=%0d found=%b amount=%0d, required %0d 1 0", lat, found, amount, MALL ? 17 : 2);
    end
    tests_run++;
    if (match_mask !== (MALL ? 16'h0001 : 16'h0000)) begin
      failed++;
      $display("FAIL identity_mask: got %h, required %h", match_mask, MALL ? 16'h0001 : 16'h0000);
    end
  endtask

  task automatic test_no_match();
    int lat, bc;
    do_start(16'h0000, 16'h0001);
    wait_done(1, lat, bc);
    tests_run++;
    if (lat !== 17 || found !== 1'b0 || amount !== 4'd0 || match_mask !== 16'h0000) begin
      failed++;
      $display("FAIL no_match: lat=%0d found=%b amount=%0d mask=%h, required 17 0 0 0000",
               lat, found, amount, match_mask);
    end
  endtask

  task automatic test_multi_match();
    int lat, bc;
    do_start(16'h0101, 16'h1010);
    wait_done(1, lat, bc);
    tests_run++;
    if (lat !== (MALL ? 17 : 6) || found !== 1'b1 || amount !== 4'd4) begin
      failed++;
      $display("FAIL multi_match: lat=%0d found=%b amount=%0d, required %0d 1 4", lat, found, amount, MALL ? 17 : 6);
    end
    tests_run++;
    if (match_mask !== (MALL ? 16'h1010 : 16'h0000)) begin
      failed++;
      $display("FAIL multi_mask: got %h, required %h", match_mask, MALL ? 16'h1010 : 16'h0000);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    // Original request matches at amount 8; the stray starts would match at 1.
    do_start(16'h0001, 16'h0100);
    @(negedge clk);
    start = 1'b1; data_in = 16'h0001; target_in = 16'h0002;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat, bc);
    tests_run++;
    if (lat !== (MALL ? 17 : 10) || found !== 1'b1 || amount !== 4'd8) begin
      failed++;
      $display("FAIL ignored_start: lat=%0d found=%b amount=%0d, required %0d 1 8", lat, found, amount, MALL ? 17 : 10);
    end
    // Start held through the DONE cycle: ignored there, accepted in the first IDLE cycle.
    start = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || amount !== 4'd8) begin
      failed++;
      $display("FAIL done_cycle_start: busy=%b done=%b amount=%0d, required 0 0 8", busy, done, amount);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, bc);
    tests_run++;
    if (lat !== (MALL ? 17 : 3) || found !== 1'b1 || amount !== 4'd1) begin
      failed++;
      $display("FAIL idle_start_accepted: lat=%0d found=%b amount=%0d, required %0d 1 1", lat, found, amount, MALL ? 17 : 3);
    end
  endtask

  task automatic test_reset_mid_scan();
    int saw_done;
    do_start(16'h0000, 16'h0001);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, done, found, amount, match_mask} !== {1'b0, 1'b0, 1'b0, {SW{1'b0}}, 16'h0000}) begin
      failed++;
      $display("FAIL reset_mid_scan: busy=%b done=%b found=%b amount=%0d mask=%h, required all zero",
               busy, done, found, amount, match_mask);
    end
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done++;
    end
    tests_run++;
    if (saw_done !== 0) begin
      failed++;
      $display("FAIL aborted_scan_quiet: %0d cycles with done/busy set, required 0", saw_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_identity();
    test_no_match();
    test_multi_match();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
